// File: rtl/seg7_scan_drv_if.sv
// Display bus between the clock counter group and the 7-segment scan driver.
// master: counter side (drives BCD digits and mode), slave: scan driver.
interface seg7_scan_drv_if;
   logic [3:0] msb_h;
   logic [3:0] lsb_h;
   logic [3:0] msb_m;
   logic [3:0] lsb_m;
   logic [3:0] msb_s;
   logic [3:0] lsb_s;
   logic [1:0] mode_flag;
   logic [5:0] an;
   logic [6:0] seg;
   logic       dp;

   modport master (
      output msb_h, lsb_h, msb_m, lsb_m, msb_s, lsb_s, mode_flag,
      input  an, seg, dp
   );

   modport slave (
      input  msb_h, lsb_h, msb_m, lsb_m, msb_s, lsb_s, mode_flag,
      output an, seg, dp
   );
endinterface

// File: rtl/seg7_scan_drv.sv
// Six-digit 7-segment scan driver for an hh:mm:ss clock.
// Time-multiplexes the BCD digits onto a shared segment bus, blanks the anodes for
// one clock at each slot start, and blinks the field selected by mode_flag.
// Optional feature: define SEG7_SEP_DP_EN to light separator decimal points on
// digits 2 and 4 (digit 2 pulses with the blink phase in run mode).
module seg7_scan_drv #(
   parameter int unsigned SCAN_DIV    = 100,
   parameter int unsigned BLINK_DIV   = 25000,
   parameter bit          SEG_ACT_LOW = 1'b1,
   parameter bit          AN_ACT_LOW  = 1'b1
) (
   input logic            clk100khz,
   input logic            rst,
   seg7_scan_drv_if.slave bus
);

   localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
   localparam logic [5:0] AN_OFF   = AN_ACT_LOW ? 6'h3F : 6'h00;
   localparam logic [6:0] SEG_OFF  = SEG_ACT_LOW ? 7'h7F : 7'h00;
   localparam logic       DP_OFF   = SEG_ACT_LOW;
   localparam logic [6:0] SEG_POL  = {7{SEG_ACT_LOW}};
   localparam logic [5:0] AN_POL   = {6{AN_ACT_LOW}};

   // Parameter sanity: a slot needs a ghost cycle plus at least one lit cycle.
   if (SCAN_DIV < 2) begin : g_bad_scan_div
      $error("seg7_scan_drv: SCAN_DIV must be >= 2");
   end
   if (BLINK_DIV < 1) begin : g_bad_blink_div
      $error("seg7_scan_drv: BLINK_DIV must be >= 1");
   end

   logic [SCAN_W-1:0]  r_scan_cnt, w_scan_nxt;
   logic [2:0]         r_dig_idx, w_idx_nxt;
   logic [BLINK_W-1:0] r_blink_cnt, w_blink_nxt;
   logic               r_phase, w_phase_nxt;   // 1 = ON
   logic [1:0]         r_mode_sh, w_mode_nxt;
   logic [5:0]         r_an, w_an_nxt;
   logic [6:0]         r_seg, w_seg_nxt;
   logic               r_dp, w_dp_nxt;

   logic               w_scan_wrap;
   logic [3:0]         w_dig_val;
   logic               w_blank;
   logic               w_dp_on;
   logic [6:0]         w_seg_raw;

   // Active-high segment pattern {g,f,e,d,c,b,a}; 10-15 render as a dash.
   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      unique case (v)
         4'd0:    seg_decode = 7'h3F;
         4'd1:    seg_decode = 7'h06;
         4'd2:    seg_decode = 7'h5B;
         4'd3:    seg_decode = 7'h4F;
         4'd4:    seg_decode = 7'h66;
         4'd5:    seg_decode = 7'h6D;
         4'd6:    seg_decode = 7'h7D;
         4'd7:    seg_decode = 7'h07;
         4'd8:    seg_decode = 7'h7F;
         4'd9:    seg_decode = 7'h6F;
         default: seg_decode = 7'h40;
      endcase
   endfunction

   // Scan slot counter and digit index sequencing.
   always_comb begin
      w_scan_wrap = (r_scan_cnt == SCAN_LAST);
      w_scan_nxt  = w_scan_wrap ? '0 : r_scan_cnt + 1'b1;
      w_idx_nxt   = r_dig_idx;
      if (w_scan_wrap) begin
         w_idx_nxt = (r_dig_idx == 3'd5) ? 3'd0 : r_dig_idx + 3'd1;
      end
   end

   // Blink timebase; a mode change restarts the blink with the field visible.
   always_comb begin
      w_blink_nxt = r_blink_cnt;
      w_phase_nxt = r_phase;
      w_mode_nxt  = r_mode_sh;
      if (bus.mode_flag != r_mode_sh) begin
         w_blink_nxt = '0;
         w_phase_nxt = 1'b1;
         w_mode_nxt  = bus.mode_flag;
      end else if (r_blink_cnt == BLINK_LAST) begin
         w_blink_nxt = '0;
         w_phase_nxt = ~r_phase;
      end else begin
         w_blink_nxt = r_blink_cnt + 1'b1;
      end
   end

   // Select the digit for the current index and decide blanking for its slot.
   always_comb begin
      unique case (r_dig_idx)
         3'd0:    w_dig_val = bus.lsb_s;
         3'd1:    w_dig_val = bus.msb_s;
         3'd2:    w_dig_val = bus.lsb_m;
         3'd3:    w_dig_val = bus.msb_m;
         3'd4:    w_dig_val = bus.lsb_h;
         3'd5:    w_dig_val = bus.msb_h;
         default: w_dig_val = 4'd0;
      endcase
      // Field pairs: mode 1 -> digits 0-1, mode 2 -> 2-3, mode 3 -> 4-5.
      w_blank   = !r_phase && (r_mode_sh != 2'd0) && (r_dig_idx[2:1] == r_mode_sh - 2'd1);
      w_seg_raw = seg_decode(w_dig_val);
`ifdef SEG7_SEP_DP_EN
      // Separators after hours and minutes; minutes separator pulses in run mode.
      w_dp_on = !w_blank &&
                ((r_dig_idx == 3'd4) ||
                 ((r_dig_idx == 3'd2) && ((r_mode_sh != 2'd0) || r_phase)));
`else
      w_dp_on = 1'b0;
`endif
   end

   // Output next-state: latch a slot's content at its start, blank anodes on the wrap.
   always_comb begin
      w_an_nxt  = r_an;
      w_seg_nxt = r_seg;
      w_dp_nxt  = r_dp;
      if (r_scan_cnt == '0) begin
         w_an_nxt  = (6'd1 << r_dig_idx) ^ AN_POL;
         w_seg_nxt = w_blank ? SEG_OFF : (w_seg_raw ^ SEG_POL);
         w_dp_nxt  = w_dp_on ? ~DP_OFF : DP_OFF;
      end else if (w_scan_wrap) begin
         w_an_nxt = AN_OFF;
      end
   end

   // State and output registers.
   always_ff @(posedge clk100khz or posedge rst) begin
      if (rst) begin
         r_scan_cnt  <= '0;
         r_dig_idx   <= 3'd0;
         r_blink_cnt <= '0;
         r_phase     <= 1'b1;
         r_mode_sh   <= 2'd0;
         r_an        <= AN_OFF;
         r_seg       <= SEG_OFF;
         r_dp        <= DP_OFF;
      end else begin
         r_scan_cnt  <= w_scan_nxt;
         r_dig_idx   <= w_idx_nxt;
         r_blink_cnt <= w_blink_nxt;
         r_phase     <= w_phase_nxt;
         r_mode_sh   <= w_mode_nxt;
         r_an        <= w_an_nxt;
         r_seg       <= w_seg_nxt;
         r_dp        <= w_dp_nxt;
      end
   end

   assign bus.an  = r_an;
   assign bus.seg = r_seg;
   assign bus.dp  = r_dp;

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Self-checking bench for seg7_scan_drv: time-based reference model plus directed literals.
module tb_seg7_scan_drv;

   localparam int unsigned SCAN_DIV  = 8;
   localparam int unsigned BLINK_DIV = 40;
   localparam logic [5:0]  AN_OFF    = 6'h3F;
   localparam logic [6:0]  SEG_OFF   = 7'h7F;
   localparam logic        DP_OFF    = 1'b1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_err    = 0;

   seg7_scan_drv_if u_if ();

   seg7_scan_drv #(
      .SCAN_DIV    (SCAN_DIV),
      .BLINK_DIV   (BLINK_DIV),
      .SEG_ACT_LOW (1'b1),
      .AN_ACT_LOW  (1'b1)
   ) u_dut (
      .clk100khz (clk),
      .rst       (rst),
      .bus       (u_if.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Lit segments {g,f,e,d,c,b,a} for each character of a standard 7-segment display.
   function automatic logic [6:0] glyph(input logic [3:0] v);
      case (v)
         4'd0:    glyph = 7'b0111111;
         4'd1:    glyph = 7'b0000110;
         4'd2:    glyph = 7'b1011011;
         4'd3:    glyph = 7'b1001111;
         4'd4:    glyph = 7'b1100110;
         4'd5:    glyph = 7'b1101101;
         4'd6:    glyph = 7'b1111101;
         4'd7:    glyph = 7'b0000111;
         4'd8:    glyph = 7'b1111111;
         4'd9:    glyph = 7'b1101111;
         default: glyph = 7'b1000000;
      endcase
   endfunction

   function automatic logic [3:0] digit_at(input int i);
      case (i)
         0:       digit_at = u_if.lsb_s;
         1:       digit_at = u_if.msb_s;
         2:       digit_at = u_if.lsb_m;
         3:       digit_at = u_if.msb_m;
         4:       digit_at = u_if.lsb_h;
         default: digit_at = u_if.msb_h;
      endcase
   endfunction

   // Reference model: position in time since reset / since last mode change.
   initial begin : cmp
      int         k;
      int         age;
      int         scan;
      int         idx;
      logic [1:0] msh;
      logic [1:0] mode_in;
      logic [6:0] slot_seg;
      logic       slot_dp;
      logic [5:0] exp_an;
      bit         phase_on;
      bit         blank;
      bit         dp_on;
      k = 0; age = 0; msh = 2'd0; slot_seg = SEG_OFF; slot_dp = DP_OFF;
      forever begin
         @(negedge clk);
         mode_in = u_if.mode_flag;
         if (rst) begin
            k = 0; age = 0; msh = 2'd0; slot_seg = SEG_OFF; slot_dp = DP_OFF;
            check("an_in_reset", 32'(u_if.an), 32'(AN_OFF));
            check("seg_in_reset", 32'(u_if.seg), 32'(SEG_OFF));
         end else begin
            scan = k % SCAN_DIV;
            idx  = (k / SCAN_DIV) % 6;
            exp_an = (scan == 0) ? AN_OFF : ~(6'd1 << idx);
            check("an", 32'(u_if.an), 32'(exp_an));
            check("seg", 32'(u_if.seg), 32'(slot_seg));
            check("dp", 32'(u_if.dp), 32'(slot_dp));
            if (scan == 0) begin
               phase_on = ((age / BLINK_DIV) % 2) == 0;
               blank    = !phase_on && (msh != 2'd0) && ((idx / 2 + 1) == int'(msh));
`ifdef SEG7_SEP_DP_EN
               dp_on = !blank && ((idx == 4) || (idx == 2 && (msh != 2'd0 || phase_on)));
`else
               dp_on = 1'b0;
`endif
               slot_seg = blank ? SEG_OFF : ~glyph(digit_at(idx));
               slot_dp  = dp_on ? 1'b0 : 1'b1;
            end
         end
         @(posedge clk);
         if (!rst) begin
            k++;
            if (mode_in != msh) begin
               age = 0;
               msh = mode_in;
            end else begin
               age++;
            end
         end
      end
   end

   task automatic randomize_inputs();
      if ($urandom_range(0, 7) == 0) begin
         case ($urandom_range(0, 5))
            0:       u_if.lsb_s = 4'($urandom_range(0, 15));
            1:       u_if.msb_s = 4'($urandom_range(0, 15));
            2:       u_if.lsb_m = 4'($urandom_range(0, 15));
            3:       u_if.msb_m = 4'($urandom_range(0, 15));
            4:       u_if.lsb_h = 4'($urandom_range(0, 15));
            default: u_if.msb_h = 4'($urandom_range(0, 15));
         endcase
      end
      if ($urandom_range(0, 149) == 0) u_if.mode_flag = 2'($urandom_range(0, 3));
   endtask

   initial begin : stim
      u_if.msb_h = 4'd1; u_if.lsb_h = 4'd2;
      u_if.msb_m = 4'd3; u_if.lsb_m = 4'd4;
      u_if.msb_s = 4'd5; u_if.lsb_s = 4'd6;
      u_if.mode_flag = 2'd0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;

      // 12:34:56 run mode: first slot, ghost cycle, second slot.
      @(posedge clk); #3;
      check("slot0_an", 32'(u_if.an), 32'h3E);
      check("slot0_seg_6", 32'(u_if.seg), 32'h02);
      check("slot0_dp", 32'(u_if.dp), 32'h1);
      repeat (SCAN_DIV - 1) @(posedge clk);
      #3;
      check("ghost_an", 32'(u_if.an), 32'h3F);
      check("ghost_seg_hold", 32'(u_if.seg), 32'h02);
      @(posedge clk); #3;
      check("slot1_an", 32'(u_if.an), 32'h3D);
      check("slot1_seg_5", 32'(u_if.seg), 32'h12);

      repeat (2 * 6 * SCAN_DIV) @(posedge clk);
      #1 u_if.mode_flag = 2'd2;
      repeat (5 * BLINK_DIV) @(posedge clk);
      #1 u_if.mode_flag = 2'd1;
      repeat (BLINK_DIV + 15) @(posedge clk);
      #1 u_if.mode_flag = 2'd3;
      repeat (4 * BLINK_DIV) @(posedge clk);
      #1 u_if.mode_flag = 2'd0;
      repeat (3 * BLINK_DIV) @(posedge clk);

      // Async reset mid-slot, then dash on digit 0 and no mid-slot tearing.
      #3 rst = 1'b1;
      #1;
      check("rst_async_an", 32'(u_if.an), 32'h3F);
      check("rst_async_seg", 32'(u_if.seg), 32'h7F);
      check("rst_async_dp", 32'(u_if.dp), 32'h1);
      u_if.lsb_s = 4'hB;
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk); #3;
      check("dash_an", 32'(u_if.an), 32'h3E);
      check("dash_seg", 32'(u_if.seg), 32'h3F);
      u_if.lsb_s = 4'h1;
      repeat (2) @(posedge clk);
      #3;
      check("no_tear_seg", 32'(u_if.seg), 32'h3F);
      check("no_tear_an", 32'(u_if.an), 32'h3E);

      // Randomized digits and mode changes, with a reset in the middle.
      repeat (4000) begin
         @(posedge clk);
         #1 randomize_inputs();
      end
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      repeat (4000) begin
         @(posedge clk);
         #1 randomize_inputs();
      end

      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
